// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//
// Central arbiter for the single SDRAM command/address bus. It shares the bus
// between the init, auto-refresh, write and read sub-modules. All traffic is
// held off until power-up initialization completes. After that, one requester
// is granted at a time by priority: refresh first, then write, then read. The
// granted requester's command, address and bank are muxed onto registered
// SDRAM pins.
//
// Optional build macro:
//   SDRAM_ARB_RR_EN - write and read share round-robin priority through a
//                     last-served flag. Refresh keeps absolute top priority.
//                     When the macro is undefined, write always wins over read.
//
// Ports:
//   sdram_clk, rst_n          clock and asynchronous active-low reset
//   init_done                 level, power-up init sequence complete
//   init_cmd, init_addr       init module command and address
//   aref_req, aref_done       refresh request level and finished pulse
//   aref_cmd                  refresh module command
//   aref_en                   refresh grant pulse
//   wr_req, wr_cmd, wr_addr,  write module request, command, address and bank
//   wr_ba
//   go_aref_wr, wr_done_all   write yield pulse and write complete pulse
//   wr_en                     write grant pulse
//   rd_req, rd_cmd, rd_addr,  read module request, command, address and bank
//   rd_ba
//   go_aref_rd, rd_done_all   read yield pulse and read complete pulse
//   rd_en                     read grant pulse
//   sdram_cmd, sdram_addr,    registered {CS_n,RAS_n,CAS_n,WE_n}, address and
//   sdram_ba                  bank driven to the SDRAM pins
//   arb_busy                  high whenever the arbiter is not idle

module sdram_arbiter #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned BA_BITS   = 2
) (
  input  logic                 sdram_clk,
  input  logic                 rst_n,

  input  logic                 init_done,
  input  logic [3:0]           init_cmd,
  input  logic [ADDR_BITS-1:0] init_addr,

  input  logic                 aref_req,
  input  logic                 aref_done,
  input  logic [3:0]           aref_cmd,
  output logic                 aref_en,

  input  logic                 wr_req,
  input  logic [3:0]           wr_cmd,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic                 go_aref_wr,
  input  logic                 wr_done_all,
  output logic                 wr_en,

  input  logic                 rd_req,
  input  logic [3:0]           rd_cmd,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic [BA_BITS-1:0]   rd_ba,
  input  logic                 go_aref_rd,
  input  logic                 rd_done_all,
  output logic                 rd_en,

  output logic [3:0]           sdram_cmd,
  output logic [ADDR_BITS-1:0] sdram_addr,
  output logic [BA_BITS-1:0]   sdram_ba,
  output logic                 arb_busy
);

  localparam logic [3:0] CmdNop = 4'b0111;

  typedef enum logic [2:0] {
    ArbInit  = 3'd0,
    ArbIdle  = 3'd1,
    ArbAref  = 3'd2,
    ArbWrite = 3'd3,
    ArbRead  = 3'd4
  } arb_state_e;

  arb_state_e state_q, state_d;

  logic                 aref_en_q, aref_en_d;
  logic                 wr_en_q,   wr_en_d;
  logic                 rd_en_q,   rd_en_d;

  logic [3:0]           cmd_q,  cmd_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [BA_BITS-1:0]   ba_q,   ba_d;

  // Write wins the idle-state arbitration against read when this is high.
  logic                 wr_wins;

`ifdef SDRAM_ARB_RR_EN
  // High when write was the last of write/read to be granted. Resets to
  // "read served last" so that write wins the first tie.
  logic last_wr_q, last_wr_d;

  assign wr_wins = wr_req && (!rd_req || !last_wr_q);

  always_comb begin
    last_wr_d = last_wr_q;
    if (wr_en_d) begin
      last_wr_d = 1'b1;
    end else if (rd_en_d) begin
      last_wr_d = 1'b0;
    end
  end

  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr_q <= 1'b0;
    end else begin
      last_wr_q <= last_wr_d;
    end
  end
`else
  assign wr_wins = wr_req;
`endif

  // Next-state and pin mux. The mux is selected by the current state, so the
  // pins lag the muxed source by exactly one register stage in every state.
  always_comb begin
    state_d = state_q;
    cmd_d   = CmdNop;
    addr_d  = '0;
    ba_d    = '0;

    unique case (state_q)
      ArbInit: begin
        cmd_d  = init_cmd;
        addr_d = init_addr;
        if (init_done) begin
          state_d = ArbIdle;
        end
      end

      ArbIdle: begin
        if (aref_req) begin
          state_d = ArbAref;
        end else if (wr_wins) begin
          state_d = ArbWrite;
        end else if (rd_req) begin
          state_d = ArbRead;
        end
      end

      ArbAref: begin
        cmd_d = aref_cmd;
        if (aref_done) begin
          state_d = ArbIdle;
        end
      end

      ArbWrite: begin
        cmd_d  = wr_cmd;
        addr_d = wr_addr;
        ba_d   = wr_ba;
        // No preemption: refresh only gets in once the writer yields.
        if (wr_done_all || go_aref_wr) begin
          state_d = ArbIdle;
        end
      end

      ArbRead: begin
        cmd_d  = rd_cmd;
        addr_d = rd_addr;
        ba_d   = rd_ba;
        if (rd_done_all || go_aref_rd) begin
          state_d = ArbIdle;
        end
      end

      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  // Grant pulses are registered together with the state, so each is high for
  // the first cycle of the granted state only.
  always_comb begin
    aref_en_d = (state_q == ArbIdle) && (state_d == ArbAref);
    wr_en_d   = (state_q == ArbIdle) && (state_d == ArbWrite);
    rd_en_d   = (state_q == ArbIdle) && (state_d == ArbRead);
  end

  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ArbInit;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cmd_q     <= CmdNop;
      addr_q    <= '0;
      ba_q      <= '0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      ba_q      <= ba_d;
    end
  end

  assign aref_en    = aref_en_q;
  assign wr_en      = wr_en_q;
  assign rd_en      = rd_en_q;
  assign sdram_cmd  = cmd_q;
  assign sdram_addr = addr_q;
  assign sdram_ba   = ba_q;
  assign arb_busy   = (state_q != ArbIdle);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.

module tb_sdram_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned BW = 2;
  localparam logic [3:0]  NOP = 4'b0111;

  logic          sdram_clk = 1'b0;
  logic          rst_n;
  logic          init_done;
  logic [3:0]    init_cmd;
  logic [AW-1:0] init_addr;
  logic          aref_req, aref_done;
  logic [3:0]    aref_cmd;
  logic          aref_en;
  logic          wr_req;
  logic [3:0]    wr_cmd;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_ba;
  logic          go_aref_wr, wr_done_all, wr_en;
  logic          rd_req;
  logic [3:0]    rd_cmd;
  logic [AW-1:0] rd_addr;
  logic [BW-1:0] rd_ba;
  logic          go_aref_rd, rd_done_all, rd_en;
  logic [3:0]    sdram_cmd;
  logic [AW-1:0] sdram_addr;
  logic [BW-1:0] sdram_ba;
  logic          arb_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sdram_clk = ~sdram_clk;

  sdram_arbiter #(
    .ADDR_BITS(AW),
    .BA_BITS  (BW)
  ) u_dut (
    .sdram_clk  (sdram_clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .init_cmd   (init_cmd),
    .init_addr  (init_addr),
    .aref_req   (aref_req),
    .aref_done  (aref_done),
    .aref_cmd   (aref_cmd),
    .aref_en    (aref_en),
    .wr_req     (wr_req),
    .wr_cmd     (wr_cmd),
    .wr_addr    (wr_addr),
    .wr_ba      (wr_ba),
    .go_aref_wr (go_aref_wr),
    .wr_done_all(wr_done_all),
    .wr_en      (wr_en),
    .rd_req     (rd_req),
    .rd_cmd     (rd_cmd),
    .rd_addr    (rd_addr),
    .rd_ba      (rd_ba),
    .go_aref_rd (go_aref_rd),
    .rd_done_all(rd_done_all),
    .rd_en      (rd_en),
    .sdram_cmd  (sdram_cmd),
    .sdram_addr (sdram_addr),
    .sdram_ba   (sdram_ba),
    .arb_busy   (arb_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sdram_clk);
    #1;
  endtask

  // Grant pulses packed as {aref_en, wr_en, rd_en}.
  function automatic logic [31:0] grants();
    return {29'd0, aref_en, wr_en, rd_en};
  endfunction

  logic [31:0] exp_seq [3];

  initial begin
    rst_n = 1'b0;
    init_done = 1'b0; init_cmd = 4'b0010; init_addr = 12'h400;
    aref_req = 1'b0; aref_done = 1'b0; aref_cmd = 4'b0001;
    wr_req = 1'b0; wr_cmd = 4'b0100; wr_addr = 12'h0ab; wr_ba = 2'd1;
    go_aref_wr = 1'b0; wr_done_all = 1'b0;
    rd_req = 1'b0; rd_cmd = 4'b0101; rd_addr = 12'h123; rd_ba = 2'd2;
    go_aref_rd = 1'b0; rd_done_all = 1'b0;

    // 1: reset values, then init pass-through until init_done
    #12;
    check_val("rst_cmd", 32'(sdram_cmd), 32'(NOP));
    check_val("rst_addr", 32'(sdram_addr), 32'h0);
    check_val("rst_en", grants(), 32'h0);
    check_val("rst_busy", 32'(arb_busy), 32'h1);
    rst_n = 1'b1;
    wr_req = 1'b1;  // must be ignored until init completes
    step();
    check_val("init_cmd", 32'(sdram_cmd), 32'h2);
    check_val("init_addr", 32'(sdram_addr), 32'h400);
    for (int i = 0; i < 8; i++) step();
    check_val("init_no_en", grants(), 32'h0);
    check_val("init_busy", 32'(arb_busy), 32'h1);
    wr_req = 1'b0;
    init_done = 1'b1;
    step();
    check_val("idle_busy", 32'(arb_busy), 32'h0);
    check_val("idle_cmd_lag", 32'(sdram_cmd), 32'h2);
    step();
    check_val("idle_cmd_nop", 32'(sdram_cmd), 32'(NOP));
    check_val("idle_addr", 32'(sdram_addr), 32'h0);
    check_val("idle_no_en", grants(), 32'h0);

    // 2: lone read
    rd_req = 1'b1;
    step();
    check_val("rd_grant", grants(), 32'h1);
    check_val("rd_busy", 32'(arb_busy), 32'h1);
    rd_req = 1'b0;
    step();
    check_val("rd_en_once", grants(), 32'h0);
    check_val("rd_cmd", 32'(sdram_cmd), 32'h5);
    check_val("rd_addr", 32'(sdram_addr), 32'h123);
    check_val("rd_ba", 32'(sdram_ba), 32'h2);
    rd_done_all = 1'b1;
    step();
    rd_done_all = 1'b0;
    check_val("rd_done_busy", 32'(arb_busy), 32'h0);
    check_val("rd_done_cmd_lag", 32'(sdram_cmd), 32'h5);
    step();
    check_val("rd_done_nop", 32'(sdram_cmd), 32'(NOP));

    // 3: all three request at once
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step();
    check_val("pri_aref", grants(), 32'h4);
    aref_req = 1'b0;
    step();
    check_val("aref_cmd", 32'(sdram_cmd), 32'h1);
    check_val("aref_addr", 32'(sdram_addr), 32'h0);
    check_val("aref_ba", 32'(sdram_ba), 32'h0);
    aref_done = 1'b1;
    step();
    aref_done = 1'b0;
    check_val("pri_gap1", grants(), 32'h0);
    check_val("pri_gap1_busy", 32'(arb_busy), 32'h0);
    step();
    check_val("pri_wr", grants(), 32'h2);
    wr_req = 1'b0;
    step();
    check_val("wr_cmd", 32'(sdram_cmd), 32'h4);
    check_val("wr_addr", 32'(sdram_addr), 32'h0ab);
    check_val("wr_ba", 32'(sdram_ba), 32'h1);
    wr_done_all = 1'b1;
    step();
    wr_done_all = 1'b0;
    check_val("pri_gap2", grants(), 32'h0);
    step();
    check_val("pri_rd", grants(), 32'h1);
    step();

    // 4: refresh raised during a read, no preemption until the reader yields
    aref_req = 1'b1;
    step();
    check_val("nopreempt_busy", 32'(arb_busy), 32'h1);
    check_val("nopreempt_en", grants(), 32'h0);
    check_val("nopreempt_cmd", 32'(sdram_cmd), 32'h5);
    go_aref_rd = 1'b1;
    step();
    go_aref_rd = 1'b0;
    check_val("yield_idle", 32'(arb_busy), 32'h0);
    check_val("yield_no_en", grants(), 32'h0);
    step();
    check_val("yield_aref", grants(), 32'h4);
    aref_req = 1'b0;
    step();
    aref_done = 1'b1;
    step();
    aref_done = 1'b0;
    step();
    check_val("yield_regrant", grants(), 32'h1);
    rd_req = 1'b0;
    rd_done_all = 1'b1;
    step();
    rd_done_all = 1'b0;
    step();

    // 5: write and read both held; read was served last
`ifdef SDRAM_ARB_RR_EN
    exp_seq = '{32'h2, 32'h1, 32'h2};
`else
    exp_seq = '{32'h2, 32'h2, 32'h2};
`endif
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("seq_%0d", i), grants(), exp_seq[i]);
      step();
      wr_done_all = wr_en ? 1'b0 : (u_dut.wr_en == 1'b0 && exp_seq[i] == 32'h2);
      rd_done_all = (exp_seq[i] == 32'h1);
      step();
      wr_done_all = 1'b0; rd_done_all = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    step();
    check_val("seq_end_idle", 32'(arb_busy), 32'h0);

    // 6: asynchronous reset in the middle of a write
    wr_req = 1'b1;
    step();
    check_val("rst_wr_grant", grants(), 32'h2);
    wr_req = 1'b0;
    step();
    check_val("rst_wr_cmd", 32'(sdram_cmd), 32'h4);
    #3 rst_n = 1'b0;
    #1;
    check_val("async_cmd", 32'(sdram_cmd), 32'(NOP));
    check_val("async_addr", 32'(sdram_addr), 32'h0);
    check_val("async_ba", 32'(sdram_ba), 32'h0);
    check_val("async_en", grants(), 32'h0);
    check_val("async_busy", 32'(arb_busy), 32'h1);
    init_done = 1'b0;
    #2 rst_n = 1'b1;
    aref_req = 1'b1; wr_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_val("reinit_no_en", grants(), 32'h0);
    check_val("reinit_cmd", 32'(sdram_cmd), 32'h2);
    init_done = 1'b1;
    step();
    check_val("reinit_idle", 32'(arb_busy), 32'h0);
    step();
    check_val("reinit_aref", grants(), 32'h4);
    aref_req = 1'b0; wr_req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Central arbiter for the single SDRAM command/address bus. It shares the bus between the init, auto-refresh, write and read sub-modules. It holds off all traffic until initialization completes, then grants one requester at a time by priority. It muxes the granted requester's {CS_n,RAS_n,CAS_n,WE_n}, address and bank onto registered SDRAM pins.

Parameters:
ADDR_BITS, 12, SDRAM address width (A11..A0)
BA_BITS, 2, bank address width

Ports:
sdram_clk  input  1  SDRAM clock
rst_n  input  1  asynchronous active-low reset
init_done  input  1  level, power-up init sequence complete
init_cmd  input  4  init module command
init_addr  input  ADDR_BITS  init module address (mode register value)
aref_req  input  1  level, refresh due
aref_done  input  1  one-cycle pulse, refresh sequence finished
aref_cmd  input  4  refresh module command
aref_en  output  1  refresh grant pulse
wr_req  input  1  level, write module requesting bus
wr_cmd  input  4  write module command
wr_addr  input  ADDR_BITS  write module address
wr_ba  input  BA_BITS  write module bank
go_aref_wr  input  1  pulse, write yielded bus for refresh
wr_done_all  input  1  pulse, write transfer complete
wr_en  output  1  write grant pulse
rd_req  input  1  level, read module requesting bus
rd_cmd  input  4  read module command
rd_addr  input  ADDR_BITS  read module address
rd_ba  input  BA_BITS  read module bank
go_aref_rd  input  1  pulse, read yielded bus for refresh
rd_done_all  input  1  pulse, read transfer complete
rd_en  output  1  read grant pulse
sdram_cmd  output  4  registered command to SDRAM pins
sdram_addr  output  ADDR_BITS  registered address to SDRAM pins
sdram_ba  output  BA_BITS  registered bank to SDRAM pins
arb_busy  output  1  high when state is not ARB_IDLE

Behaviour:
- Clock is sdram_clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=ARB_INIT; aref_en=wr_en=rd_en=0; sdram_cmd=4'b0111 (NOP); sdram_addr=0; sdram_ba=0; arb_busy=1.
- States:
  - ARB_INIT: mux init_cmd/init_addr, ba=0. Go to ARB_IDLE when init_done=1.
  - ARB_IDLE: mux NOP/0/0. Arbitrate with priority aref_req > wr_req > rd_req. Move to ARB_AREF, ARB_WRITE or ARB_READ. Stay in ARB_IDLE if there is no request.
  - ARB_AREF: mux aref_cmd, addr=0, ba=0. Go to ARB_IDLE on aref_done.
  - ARB_WRITE: mux wr_cmd/wr_addr/wr_ba. Go to ARB_IDLE on wr_done_all or go_aref_wr.
  - ARB_READ: mux rd_cmd/rd_addr/rd_ba. Go to ARB_IDLE on rd_done_all or go_aref_rd.
  - Illegal encodings go to ARB_IDLE.
- Grant timing:
  - *_en is registered and high for exactly the first cycle after the IDLE->grant transition, i.e. the first cycle of the granted state.
  - Requests are sampled only in ARB_IDLE. A req that drops before sampling gets no grant.
- No preemption. An aref_req raised during ARB_WRITE/ARB_READ does not change state; the requester yields via go_aref_*.
  - On yield, the arbiter passes through one IDLE cycle, then enters ARB_AREF (aref_req still high).
  - The yielding requester keeps its req high and is re-granted after aref_done if it is still top priority.
- Simultaneous done and aref_req: go to IDLE, then AREF on the next cycle.
- Simultaneous done and a new req from the same requester: IDLE for one cycle, then re-arbitrate normally.
- Output pipeline: sdram_cmd/addr/ba are registered. The pin value equals the muxed source delayed exactly 1 cycle, with the same fixed latency in all states.
- Minimum turnaround from a done pulse to the next grant pulse is 2 cycles (IDLE cycle + grant cycle).
- rst_n assertion mid-operation: all outputs return to their reset values immediately; after release the arbiter re-enters ARB_INIT and waits for init_done again.
- init_done is ignored outside ARB_INIT.

Optional Feature:
SDRAM_ARB_RR_EN:
- Defined: write and read share round-robin priority via a last_served flag. The flag resets to "read", so write wins the first tie. It updates on every wr/rd grant. When wr_req and rd_req are both high in IDLE, the requester not served last wins. Refresh keeps absolute top priority.
- Undefined: fixed priority write > read; the last_served flag is not built.

Test Plan:
1. Reset, init_cmd=4'b0010/init_addr=12'h400, init_done at cycle 10 -> sdram_cmd/addr follow init inputs delayed 1 cycle; no *_en before init_done; IDLE at cycle 11.
2. rd_req alone in IDLE -> rd_en high exactly 1 cycle; sdram_cmd=rd_cmd delayed 1; rd_done_all pulse -> arb_busy=0 next cycle; sdram_cmd=NOP 1 cycle later.
3. aref_req, wr_req, rd_req all high together -> grant order aref_en, then wr_en (2 cycles after aref_done), then rd_en (2 cycles after wr_done_all).
4. During ARB_READ, raise aref_req and pulse go_aref_rd with rd_req held -> IDLE, then aref_en; after aref_done, rd_en re-granted.
5. wr_req and rd_req held continuously, each transfer completing -> with SDRAM_ARB_RR_EN grants alternate W,R,W,R; without it, W,W,W.
6. Drop rst_n mid-ARB_WRITE -> sdram_cmd=4'b0111, addr/ba=0, all *_en=0 without a clock edge; after release, no grant until init_done.
